rr_grant_ctrl: RTL and testbench

//   Round-robin arbiter and sequencer that shares one Moore-FSM datapath

---
 rtl/rr_grant_ctrl.sv | 97 +++++++++
 tb/tb_rr_grant_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_ctrl.sv
// Round-robin owner arbiter for a shared FSM datapath with a req/grant/done handshake and hold-timer reclaim.
// Grant is Moore-decoded: 2 cycles from req to grant, 1 cycle from done to grant drop, REL+ARB turnaround.
module rr_grant_ctrl #(
    parameter int N_REQ    = 4,
    parameter int OWN_W    = 2,
    parameter int HOLD_W   = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [OWN_W-1:0] owner,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic [3:0] {
        IDLE = 4'b1000,
        ARB  = 4'b0100,
        OWN  = 4'b0010,
        REL  = 4'b0001
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state;
    state_t            state_nxt;
    logic [OWN_W-1:0]  ptr;
    logic [OWN_W-1:0]  win;
    logic [HOLD_W-1:0] hold_cnt;
    logic              to_hit;
    logic              to_flag;
    logic              found;

    // Scan starts just past the previous owner, so the last owner ranks lowest.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % N_REQ]) begin
                win   = OWN_W'((int'(ptr) + i) % N_REQ);
                found = 1'b1;
            end
        end
    end

    // done wins over the timer when both land on the same edge.
    assign to_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && !done;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (|req) state_nxt = ARB;
            ARB:  state_nxt = (|req) ? OWN : IDLE;
            OWN:  if (done || !req[owner] || to_hit) state_nxt = REL;
            REL:  state_nxt = (|req) ? ARB : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= OWN_W'(N_REQ - 1);
            owner    <= '0;
            hold_cnt <= '0;
            to_flag  <= 1'b0;
        end else begin
            state   <= state_nxt;
            to_flag <= (state == OWN) && to_hit;
            case (state)
                ARB: begin
                    if (|req) begin
                        owner    <= win;
                        hold_cnt <= '0;
                    end
                end
                OWN: begin
                    if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
                end
                REL: ptr <= owner;
                default: ;
            endcase
        end
    end

    always_comb begin
        grant = '0;
        if (state == OWN) grant[owner] = 1'b1;
    end

    assign busy    = (state == ARB) || (state == OWN) || (state == REL);
    assign timeout = (state == REL) && to_flag;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl: handshake latency, rotation, hold timeout, withdrawal, reset mid-ownership.
module tb_rr_grant_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int n_chk  = 0;
    int n_fail = 0;

    rr_grant_ctrl #(
        .N_REQ   (4),
        .OWN_W   (2),
        .HOLD_W  (8),
        .MAX_HOLD(15)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .grant  (grant),
        .owner  (owner),
        .busy   (busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n edges; drive and sample 1ns after the edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    // Count zero-grant samples until a grant appears (bounded).
    task automatic wait_grant(output int zeros);
        zeros = 0;
        while (grant == 4'b0000 && zeros < 20) begin
            zeros++;
            tick();
        end
        if (zeros >= 20) check("grant_wait_timeout", 32'(zeros), 32'd0);
    endtask

    initial begin
        int gap;
        int cnt;
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // 1: reset state and single request handshake
        do_reset();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        req = 4'b0001;
        tick();
        check("t1_arb_grant", 32'(grant), 32'h0);
        check("t1_arb_busy", 32'(busy), 32'h1);
        tick();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        check("t1_rel_grant", 32'(grant), 32'h0);
        check("t1_rel_busy", 32'(busy), 32'h1);
        tick();
        check("t1_idle_busy", 32'(busy), 32'h0);
        check("t1_owner_hold", 32'(owner), 32'h0);

        // 2: all requesting, rotation with REL+ARB turnaround between owners
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(gap);
            check($sformatf("t2_grant%0d", k), 32'(grant), 32'(exp_seq[k]));
            if (k > 0) check($sformatf("t2_gap%0d", k), 32'(gap), 32'd2);
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        req = '0;
        tick(2);
        check("t2_idle", 32'(busy), 32'h0);

        // 3: owner never finishes, timer reclaims after 15 OWN cycles
        do_reset();
        req = 4'b0100;
        tick(2);
        cnt = 0;
        while (grant == 4'b0100 && cnt < 40) begin
            if (timeout) check("t3_early_timeout", 32'(timeout), 32'h0);
            cnt++;
            tick();
        end
        check("t3_own_cycles", 32'(cnt), 32'd15);
        check("t3_timeout", 32'(timeout), 32'h1);
        check("t3_rel_grant", 32'(grant), 32'h0);
        check("t3_owner", 32'(owner), 32'h2);
        tick();
        check("t3_timeout_pulse", 32'(timeout), 32'h0);
        req = '0;
        tick(2);

        // 4: withdrawal mid-ownership, then handoff to next requester
        do_reset();
        req = 4'b0110;
        tick(2);
        check("t4_grant1", 32'(grant), 32'h2);
        tick(2);
        req = 4'b0100;
        tick();
        check("t4_rel_grant", 32'(grant), 32'h0);
        check("t4_no_timeout", 32'(timeout), 32'h0);
        tick(2);
        check("t4_grant2", 32'(grant), 32'h4);
        done = 1'b1;
        req  = '0;
        tick(2);
        done = 1'b0;
        check("t4_idle", 32'(busy), 32'h0);
        check("t4_owner_hold", 32'(owner), 32'h2);

        // 5: done coincides with the last hold cycle
        do_reset();
        req = 4'b0001;
        tick(2);
        tick(14);
        check("t5_still_owned", 32'(grant), 32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t5_rel_grant", 32'(grant), 32'h0);
        check("t5_timeout", 32'(timeout), 32'h0);
        req = '0;
        tick();

        // 6: reset while owner 3 holds the grant
        do_reset();
        req = 4'b1000;
        tick(2);
        check("t6_grant3", 32'(grant), 32'h8);
        rst = 1'b1;
        req = 4'b1001;
        tick();
        check("t6_rst_grant", 32'(grant), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_timeout", 32'(timeout), 32'h0);
        rst = 1'b0;
        tick(2);
        check("t6_first_after_rst", 32'(grant), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
